// File: rtl/vdp_host_bus_bridge_pkg.sv
// Shared types for the VDP host bus bridge.
//   bus_entry_t  : one queued host access (write flag, VDP port, write data)
//   cap_state_t  : chip-select capture FSM states
//   iss_state_t  : VDP request issue FSM states
// Entry fields are sized for the widest supported bridge (ADDR_W <= 8,
// DATA_W <= 32); the bridge zero-extends on push and truncates on pop.
package vdp_bus_pkg;

  localparam int unsigned ENTRY_ADDR_W = 8;
  localparam int unsigned ENTRY_DATA_W = 32;

  // Filtered pin values while in reset: strobes idle high, port select 0.
  localparam logic STROBE_RST_VAL = 1'b1;
  localparam logic MODE_RST_VAL   = 1'b0;

  typedef struct packed {
    logic                    wr;
    logic [ENTRY_ADDR_W-1:0] adr;
    logic [ENTRY_DATA_W-1:0] data;
  } bus_entry_t;

  typedef enum logic {
    IDLE,
    HELD
  } cap_state_t;

  typedef enum logic {
    ISSUE_IDLE,
    ISSUE_REQ
  } iss_state_t;

endpackage

// File: rtl/vdp_host_bus_bridge_if.sv
// Request/acknowledge link between the host bus bridge and the VDP core.
//   req_o  : access request        wrt_o : 1 = write
//   adr_o  : VDP port              dbo_o : write data
//   dbi_i  : read data (ack cycle) ack_i : access accepted/completed
// master = bridge side, slave = VDP side.
interface vdp_host_bus_bridge_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 8
) ();

  logic              req_o;
  logic              wrt_o;
  logic [ADDR_W-1:0] adr_o;
  logic [DATA_W-1:0] dbo_o;
  logic [DATA_W-1:0] dbi_i;
  logic              ack_i;

  modport master (
    output req_o, wrt_o, adr_o, dbo_o,
    input  dbi_i, ack_i
  );

  modport slave (
    input  req_o, wrt_o, adr_o, dbo_o,
    output dbi_i, ack_i
  );

endinterface

// File: rtl/vdp_host_bus_bridge_pin_filter.sv
// Two-flop synchroniser followed by an agreement filter for one raw pin.
// The filtered output only takes a new value once FILT_LEN consecutive
// synchronised samples agree.
//   clk, reset_n : clock, async active-low reset
//   i_pin        : raw asynchronous pin
//   o_pin        : synchronised, filtered pin (RST_VAL in reset)
module pin_filter #(
  parameter int unsigned FILT_LEN = 3,
  parameter logic        RST_VAL  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_pin
);

  // bit 0 = first sync flop, bit 1 = second sync flop, above = history
  localparam int unsigned SHIFT_W = FILT_LEN + 1;

  logic [SHIFT_W-1:0] r_shift;
  logic               r_filt;
  logic               w_agree;

  // Window is the newest synchronised sample plus FILT_LEN-1 older ones.
  assign w_agree = (r_shift[FILT_LEN:1] == {FILT_LEN{r_shift[1]}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= {SHIFT_W{RST_VAL}};
      r_filt  <= RST_VAL;
    end else begin
      r_shift <= {r_shift[SHIFT_W-2:0], i_pin};
      if (w_agree) begin
        r_filt <= r_shift[1];
      end
    end
  end

  assign o_pin = r_filt;

endmodule

// File: rtl/vdp_host_bus_bridge.sv
// Host-CPU bus front end for the VDP core. Filters the host strobes and port
// select, turns each chip-select assertion into one queued access, issues
// queued accesses to the VDP over req/ack and holds read data for the host.
//   clk, reset_n   : pixel clock, async active-low reset
//   csr_n, csw_n   : raw host read/write strobes
//   mode, cd_i     : raw host port select and data bus input
//   cd_o, cd_oe    : read data to the host and bus output enable
//   vdp            : request/ack link to the VDP (master side)
//   clr_ovf        : clears the sticky overflow flag
//   overflow       : an access was dropped on a full queue
//   level          : queue occupancy
module vdp_host_bus_bridge
  import vdp_bus_pkg::*;
#(
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FILT_LEN   = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        csr_n,
  input  logic                        csw_n,
  input  logic [ADDR_W-1:0]           mode,
  input  logic [DATA_W-1:0]           cd_i,
  output logic [DATA_W-1:0]           cd_o,
  output logic                        cd_oe,
  vdp_host_bus_bridge_if.master       vdp,
  input  logic                        clr_ovf,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LEVEL_W = PTR_W + 1;

  // ---------------------------------------------------------------- pins
  logic              w_csr_f;
  logic              w_csw_f;
  logic [ADDR_W-1:0] w_mode_f;
  logic [DATA_W-1:0] r_cd_s1;
  logic [DATA_W-1:0] r_cd_s2;

  pin_filter #(.FILT_LEN(FILT_LEN), .RST_VAL(STROBE_RST_VAL)) u_csr_filt (
    .clk(clk), .reset_n(reset_n), .i_pin(csr_n), .o_pin(w_csr_f)
  );

  pin_filter #(.FILT_LEN(FILT_LEN), .RST_VAL(STROBE_RST_VAL)) u_csw_filt (
    .clk(clk), .reset_n(reset_n), .i_pin(csw_n), .o_pin(w_csw_f)
  );

  for (genvar g = 0; g < ADDR_W; g++) begin : g_mode_filt
    pin_filter #(.FILT_LEN(FILT_LEN), .RST_VAL(MODE_RST_VAL)) u_mode_filt (
      .clk(clk), .reset_n(reset_n), .i_pin(mode[g]), .o_pin(w_mode_f[g])
    );
  end

  // Data bus is only synchronised; the strobe filter delay covers settling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cd_s1 <= '0;
      r_cd_s2 <= '0;
    end else begin
      r_cd_s1 <= cd_i;
      r_cd_s2 <= r_cd_s1;
    end
  end

  // ------------------------------------------------------- capture FSM
  cap_state_t r_cap_state;
  cap_state_t w_cap_next;
  logic       w_push;
  bus_entry_t w_push_entry;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap_state <= IDLE;
    end else begin
      r_cap_state <= w_cap_next;
    end
  end

  // One push per assertion; both strobes low is treated as a bus error.
  always_comb begin
    w_cap_next = r_cap_state;
    w_push     = 1'b0;
    case (r_cap_state)
      IDLE: begin
        if (w_csr_f ^ w_csw_f) begin
          w_push     = 1'b1;
          w_cap_next = HELD;
        end else if (!w_csr_f && !w_csw_f) begin
          w_cap_next = HELD;
        end
      end
      HELD: begin
        if (w_csr_f && w_csw_f) begin
          w_cap_next = IDLE;
        end
      end
      default: w_cap_next = IDLE;
    endcase
  end

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.wr   = ~w_csw_f;
    w_push_entry.adr  = ENTRY_ADDR_W'(w_mode_f);
    w_push_entry.data = w_csw_f ? '0 : ENTRY_DATA_W'(r_cd_s2);
  end

  // ---------------------------------------------------------------- FIFO
  bus_entry_t         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;
  logic               r_overflow;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_drop;
  logic               w_wr_en;
  bus_entry_t         w_head;

  assign w_full  = (r_level == LEVEL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);
  // A pop in the same cycle frees the slot, so a full push is only lost without one.
  assign w_drop  = w_push && w_full && !w_pop;
  assign w_wr_en = w_push && !w_drop;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + LEVEL_W'(1);
        2'b01:   r_level <= r_level - LEVEL_W'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------- issue FSM
  iss_state_t        r_iss_state;
  iss_state_t        w_iss_next;
  logic              r_req;
  logic              r_wrt;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dbo;
  logic [DATA_W-1:0] r_cd_o;
  logic              r_cd_oe;

  // Returning to ISSUE_IDLE on ack guarantees one idle cycle between requests.
  always_comb begin
    w_iss_next = r_iss_state;
    w_pop      = 1'b0;
    case (r_iss_state)
      ISSUE_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_iss_next = ISSUE_REQ;
        end
      end
      ISSUE_REQ: begin
        if (vdp.ack_i) begin
          w_iss_next = ISSUE_IDLE;
        end
      end
      default: w_iss_next = ISSUE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_iss_state <= ISSUE_IDLE;
      r_req       <= 1'b0;
      r_wrt       <= 1'b0;
      r_adr       <= '0;
      r_dbo       <= '0;
      r_cd_o      <= '0;
      r_cd_oe     <= 1'b0;
    end else begin
      r_iss_state <= w_iss_next;
      r_cd_oe     <= ~w_csr_f;
      if (w_pop) begin
        r_req <= 1'b1;
        r_wrt <= w_head.wr;
        r_adr <= ADDR_W'(w_head.adr);
        r_dbo <= DATA_W'(w_head.data);
      end else if ((r_iss_state == ISSUE_REQ) && vdp.ack_i) begin
        r_req <= 1'b0;
        if (!r_wrt) begin
          r_cd_o <= vdp.dbi_i;
        end
      end
    end
  end

  assign vdp.req_o = r_req;
  assign vdp.wrt_o = r_wrt;
  assign vdp.adr_o = r_adr;
  assign vdp.dbo_o = r_dbo;
  assign cd_o      = r_cd_o;
  assign cd_oe     = r_cd_oe;
  assign overflow  = r_overflow;
  assign level     = r_level;

endmodule

// File: tb/tb_vdp_host_bus_bridge.sv
// Directed bench for vdp_host_bus_bridge (ADDR_W=2, DATA_W=8, FIFO_DEPTH=4,
// FILT_LEN=3). Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, so "after tick(n)" means after the n-th edge.
module tb_vdp_host_bus_bridge;

  logic       clk;
  logic       reset_n;
  logic       csr_n;
  logic       csw_n;
  logic [1:0] mode;
  logic [7:0] cd_i;
  logic [7:0] cd_o;
  logic       cd_oe;
  logic       clr_ovf;
  logic       overflow;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt   = 0;

  vdp_host_bus_bridge_if #(.ADDR_W(2), .DATA_W(8)) vdp_if ();

  vdp_host_bus_bridge #(
    .ADDR_W(2), .DATA_W(8), .FIFO_DEPTH(4), .FILT_LEN(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .csr_n(csr_n), .csw_n(csw_n),
    .mode(mode), .cd_i(cd_i), .cd_o(cd_o), .cd_oe(cd_oe),
    .vdp(vdp_if.master), .clr_ovf(clr_ovf), .overflow(overflow),
    .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted handshakes (req and ack both high at an edge).
  always @(posedge clk) begin
    if (vdp_if.req_o === 1'b1 && vdp_if.ack_i === 1'b1) hs_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic host_write(input logic [1:0] m, input logic [7:0] d);
    mode  = m;
    cd_i  = d;
    csw_n = 1'b0;
    tick(8);
    csw_n = 1'b1;
    tick(8);
  endtask

  task automatic test_reset;
    tick(2);
    n_checks++;
    if ({cd_o, cd_oe, vdp_if.req_o, vdp_if.wrt_o, vdp_if.adr_o, vdp_if.dbo_o, overflow, level} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cd_o=%h oe=%b req=%b wrt=%b adr=%h dbo=%h ovf=%b lvl=%0d exp all 0",
               cd_o, cd_oe, vdp_if.req_o, vdp_if.wrt_o, vdp_if.adr_o, vdp_if.dbo_o, overflow, level);
    end
    reset_n = 1'b1;
    tick(4);
    n_checks++;
    if (vdp_if.req_o !== 1'b0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got req=%b lvl=%0d exp req=0 lvl=0", vdp_if.req_o, level);
    end
  endtask

  task automatic test_single_write;
    int h0;
    h0 = hs_cnt;
    vdp_if.ack_i = 1'b1;
    mode  = 2'b01;
    cd_i  = 8'h8E;
    csw_n = 1'b0;
    tick(6);
    n_checks++;
    if (level !== 3'd1 || vdp_if.req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL write_push: got lvl=%0d req=%b exp lvl=1 req=0", level, vdp_if.req_o);
    end
    tick(1);
    n_checks++;
    if ({vdp_if.req_o, vdp_if.wrt_o, vdp_if.adr_o, vdp_if.dbo_o, level} !== {1'b1, 1'b1, 2'b01, 8'h8E, 3'd0}) begin
      n_fail++;
      $display("FAIL write_req: got req=%b wrt=%b adr=%h dbo=%h lvl=%0d exp 1 1 1 8e 0",
               vdp_if.req_o, vdp_if.wrt_o, vdp_if.adr_o, vdp_if.dbo_o, level);
    end
    tick(1);
    n_checks++;
    if (vdp_if.req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL write_req_drop: got req=%b exp 0", vdp_if.req_o);
    end
    tick(12);
    csw_n = 1'b1;
    tick(10);
    n_checks++;
    if (hs_cnt - h0 !== 1 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL write_one_pulse: got handshakes=%0d lvl=%0d exp 1 0", hs_cnt - h0, level);
    end
    vdp_if.ack_i = 1'b0;
  endtask

  task automatic test_read;
    vdp_if.ack_i = 1'b0;
    vdp_if.dbi_i = 8'h00;
    mode  = 2'b01;
    cd_i  = 8'h33;
    csr_n = 1'b0;
    tick(5);
    n_checks++;
    if (cd_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL read_oe_early: got %b exp 0", cd_oe);
    end
    tick(1);
    n_checks++;
    if (cd_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL read_oe_on: got %b exp 1", cd_oe);
    end
    tick(1);
    n_checks++;
    if ({vdp_if.req_o, vdp_if.wrt_o, vdp_if.adr_o, vdp_if.dbo_o} !== {1'b1, 1'b0, 2'b01, 8'h00}) begin
      n_fail++;
      $display("FAIL read_req: got req=%b wrt=%b adr=%h dbo=%h exp 1 0 1 00",
               vdp_if.req_o, vdp_if.wrt_o, vdp_if.adr_o, vdp_if.dbo_o);
    end
    tick(2);
    n_checks++;
    if (vdp_if.req_o !== 1'b1 || cd_o !== 8'h00) begin
      n_fail++;
      $display("FAIL read_wait: got req=%b cd_o=%h exp 1 00", vdp_if.req_o, cd_o);
    end
    vdp_if.ack_i = 1'b1;
    vdp_if.dbi_i = 8'hA5;
    tick(1);
    vdp_if.ack_i = 1'b0;
    vdp_if.dbi_i = 8'h5A;
    n_checks++;
    if (cd_o !== 8'hA5 || vdp_if.req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_data: got cd_o=%h req=%b exp a5 0", cd_o, vdp_if.req_o);
    end
    csr_n = 1'b1;
    tick(5);
    n_checks++;
    if (cd_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL read_oe_hold: got %b exp 1", cd_oe);
    end
    tick(1);
    n_checks++;
    if (cd_oe !== 1'b0 || cd_o !== 8'hA5) begin
      n_fail++;
      $display("FAIL read_oe_off: got oe=%b cd_o=%h exp 0 a5", cd_oe, cd_o);
    end
    tick(4);
  endtask

  task automatic test_burst_overflow;
    int n_seen;
    vdp_if.ack_i = 1'b0;
    for (int i = 1; i <= 6; i++) host_write(2'b10, 8'(i));
    n_checks++;
    if (level !== 3'd4 || overflow !== 1'b1 || vdp_if.req_o !== 1'b1 || vdp_if.dbo_o !== 8'h01) begin
      n_fail++;
      $display("FAIL burst_full: got lvl=%0d ovf=%b req=%b dbo=%h exp 4 1 1 01",
               level, overflow, vdp_if.req_o, vdp_if.dbo_o);
    end
    vdp_if.ack_i = 1'b1;
    n_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (vdp_if.req_o === 1'b1) begin
        n_checks++;
        if (vdp_if.dbo_o !== 8'(n_seen + 1) || vdp_if.wrt_o !== 1'b1 || vdp_if.adr_o !== 2'b10) begin
          n_fail++;
          $display("FAIL burst_order: got dbo=%h wrt=%b adr=%h exp dbo=%h wrt=1 adr=2",
                   vdp_if.dbo_o, vdp_if.wrt_o, vdp_if.adr_o, 8'(n_seen + 1));
        end
        n_seen++;
      end
      tick(1);
    end
    vdp_if.ack_i = 1'b0;
    n_checks++;
    if (n_seen !== 5 || level !== 3'd0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_count: got issued=%0d lvl=%0d ovf=%b exp 5 0 1", n_seen, level, overflow);
    end
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got %b exp 0", overflow);
    end
  endtask

  task automatic test_glitch;
    int h0;
    h0 = hs_cnt;
    vdp_if.ack_i = 1'b1;
    mode  = 2'b00;
    cd_i  = 8'h5A;
    csw_n = 1'b0;
    tick(2);
    csw_n = 1'b1;
    tick(12);
    n_checks++;
    if (hs_cnt !== h0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL glitch_reject: got handshakes=%0d lvl=%0d exp 0 0", hs_cnt - h0, level);
    end
    csw_n = 1'b0;
    tick(3);
    csw_n = 1'b1;
    tick(12);
    n_checks++;
    if (hs_cnt !== h0 + 1) begin
      n_fail++;
      $display("FAIL glitch_stable: got handshakes=%0d exp 1", hs_cnt - h0);
    end
    csr_n = 1'b0;
    csw_n = 1'b0;
    tick(10);
    csr_n = 1'b1;
    tick(10);
    n_checks++;
    if (hs_cnt !== h0 + 1 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL both_low: got handshakes=%0d lvl=%0d exp 1 0", hs_cnt - h0, level);
    end
    csw_n = 1'b1;
    tick(10);
    host_write(2'b11, 8'h77);
    n_checks++;
    if (hs_cnt !== h0 + 2) begin
      n_fail++;
      $display("FAIL rearm: got handshakes=%0d exp 2", hs_cnt - h0);
    end
    vdp_if.ack_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    int h0;
    vdp_if.ack_i = 1'b0;
    for (int i = 0; i < 4; i++) host_write(2'b11, 8'(8'h21 + i));
    n_checks++;
    if (vdp_if.req_o !== 1'b1 || level !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_setup: got req=%b lvl=%0d exp 1 3", vdp_if.req_o, level);
    end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({cd_o, cd_oe, vdp_if.req_o, vdp_if.wrt_o, vdp_if.adr_o, vdp_if.dbo_o, overflow, level} !== 24'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got cd_o=%h oe=%b req=%b wrt=%b adr=%h dbo=%h ovf=%b lvl=%0d exp all 0",
               cd_o, cd_oe, vdp_if.req_o, vdp_if.wrt_o, vdp_if.adr_o, vdp_if.dbo_o, overflow, level);
    end
    #2;
    reset_n = 1'b1;
    vdp_if.ack_i = 1'b1;
    h0 = hs_cnt;
    tick(20);
    n_checks++;
    if (hs_cnt !== h0 || vdp_if.req_o !== 1'b0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_no_stale: got handshakes=%0d req=%b lvl=%0d exp 0 0 0", hs_cnt - h0, vdp_if.req_o, level);
    end
    vdp_if.ack_i = 1'b0;
  endtask

  task automatic test_full_push_pop;
    int n_seen;
    vdp_if.ack_i = 1'b0;
    for (int i = 0; i < 5; i++) host_write(2'b00, 8'(8'h11 + i));
    n_checks++;
    if (level !== 3'd4 || overflow !== 1'b0 || vdp_if.dbo_o !== 8'h11) begin
      n_fail++;
      $display("FAIL pp_setup: got lvl=%0d ovf=%b dbo=%h exp 4 0 11", level, overflow, vdp_if.dbo_o);
    end
    mode  = 2'b00;
    cd_i  = 8'h16;
    csw_n = 1'b0;
    tick(4);
    vdp_if.ack_i = 1'b1;
    tick(1);
    vdp_if.ack_i = 1'b0;
    tick(1);
    n_checks++;
    if (level !== 3'd4 || overflow !== 1'b0 || vdp_if.req_o !== 1'b1 || vdp_if.dbo_o !== 8'h12) begin
      n_fail++;
      $display("FAIL pp_same_cycle: got lvl=%0d ovf=%b req=%b dbo=%h exp 4 0 1 12",
               level, overflow, vdp_if.req_o, vdp_if.dbo_o);
    end
    tick(2);
    csw_n = 1'b1;
    tick(8);
    vdp_if.ack_i = 1'b1;
    n_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (vdp_if.req_o === 1'b1) begin
        n_checks++;
        if (vdp_if.dbo_o !== 8'(8'h12 + n_seen)) begin
          n_fail++;
          $display("FAIL pp_order: got dbo=%h exp %h", vdp_if.dbo_o, 8'(8'h12 + n_seen));
        end
        n_seen++;
      end
      tick(1);
    end
    vdp_if.ack_i = 1'b0;
    n_checks++;
    if (n_seen !== 5 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL pp_count: got issued=%0d lvl=%0d exp 5 0", n_seen, level);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    csr_n        = 1'b1;
    csw_n        = 1'b1;
    mode         = 2'b00;
    cd_i         = 8'h00;
    clr_ovf      = 1'b0;
    vdp_if.ack_i = 1'b0;
    vdp_if.dbi_i = 8'h00;
    test_reset();
    test_single_write();
    test_read();
    test_burst_overflow();
    test_glitch();
    test_reset_mid();
    test_full_push_pop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
